// File: rtl/moore_fsm_pkg.sv
// rtl/moore_fsm_pkg.sv - shared state encoding and pattern constant for the 1011 detector
package moore_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S10  = 3'd2,
    S101 = 3'd3,
    DET  = 3'd4
  } state_e;

  localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/moore_fsm.sv
// rtl/moore_fsm.sv - Moore serial detector for 1011, valid decoded from the state register
// rst_n is active-high despite its name; it clears the state asynchronously.
module moore_fsm
  import moore_fsm_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_in,
  output logic valid
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each partial-match state advances when s_in equals the next pattern bit.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (s_in == PATTERN[3]) ? S1   : IDLE;
      S1:      state_d = (s_in == PATTERN[2]) ? S10  : S1;
      S10:     state_d = (s_in == PATTERN[1]) ? S101 : IDLE;
      S101:    state_d = (s_in == PATTERN[0]) ? DET  : S10;
      DET: begin
        if (s_in) begin
          state_d = S1;
        end else begin
          state_d = OVERLAP ? S10 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid = (state_q == DET);

endmodule

// File: tb/tb_moore_fsm.sv
// tb/tb_moore_fsm.sv - scoreboard bench for moore_fsm, overlapping and non-overlapping builds
interface ifDut;
  logic clk;
  logic rst_n;
  logic s_in;
  logic valid;
endinterface

module tb_moore_fsm;

  ifDut dut_if ();
  logic valid_no;

  int checks = 0;
  int errors = 0;
  int pulses_ov = 0;
  int pulses_no = 0;

  logic [3:0] hist_ov;
  logic [3:0] hist_no;
  logic [1:0] exp_q[$];

  moore_fsm #(.OVERLAP(1'b1)) u_dut_ov (
    .clk   (dut_if.clk),
    .rst_n (dut_if.rst_n),
    .s_in  (dut_if.s_in),
    .valid (dut_if.valid)
  );

  moore_fsm #(.OVERLAP(1'b0)) u_dut_no (
    .clk   (dut_if.clk),
    .rst_n (dut_if.rst_n),
    .s_in  (dut_if.s_in),
    .valid (valid_no)
  );

  initial dut_if.clk = 1'b0;
  always #5 dut_if.clk = ~dut_if.clk;

  // Reference: shift register of recent bits; the non-overlap copy is wiped after a hit.
  task automatic model_bit(input logic b);
    logic e_ov;
    logic e_no;
    hist_ov = {hist_ov[2:0], b};
    hist_no = {hist_no[2:0], b};
    e_ov = (hist_ov == 4'b1011);
    e_no = (hist_no == 4'b1011);
    if (e_no) hist_no = 4'b0000;
    exp_q.push_back({e_ov, e_no});
  endtask

  task automatic drive_bit(input logic b, input string name);
    logic [1:0] exp;
    @(negedge dut_if.clk);
    dut_if.s_in = b;
    model_bit(b);
    @(posedge dut_if.clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (dut_if.valid !== exp[1]) begin
        errors++;
        $display("FAIL %s ovl valid actual=%b required=%b", name, dut_if.valid, exp[1]);
      end
      checks++;
      if (valid_no !== exp[0]) begin
        errors++;
        $display("FAIL %s novl valid actual=%b required=%b", name, valid_no, exp[0]);
      end
    end
    if (dut_if.valid === 1'b1) pulses_ov++;
    if (valid_no === 1'b1) pulses_no++;
  endtask

  task automatic drive_seq(input logic [15:0] bits, input int n, input string name);
    for (int i = n - 1; i >= 0; i--) drive_bit(bits[i], name);
  endtask

  task automatic model_reset();
    hist_ov = 4'b0000;
    hist_no = 4'b0000;
    exp_q.delete();
  endtask

  // Called just after a rising edge: assert reset between edges and check the async drop.
  task automatic mid_cycle_reset(input string name);
    #2;
    dut_if.rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_if.valid !== 1'b0 || valid_no !== 1'b0) begin
      errors++;
      $display("FAIL %s async drop actual=%b%b required=00", name, dut_if.valid, valid_no);
    end
    @(negedge dut_if.clk);
    dut_if.rst_n = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge dut_if.clk);
    dut_if.rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge dut_if.clk);
      dut_if.s_in = 1'($urandom_range(0, 1));
      @(posedge dut_if.clk);
      #1;
      checks++;
      if (dut_if.valid !== 1'b0 || valid_no !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d actual=%b%b required=00", i, dut_if.valid, valid_no);
      end
    end
    @(negedge dut_if.clk);
    dut_if.rst_n = 1'b0;
    drive_seq(16'b1011, 4, "reset_prep");
    mid_cycle_reset("reset_async");
  endtask

  task automatic test_basic();
    pulses_ov = 0;
    pulses_no = 0;
    drive_seq(16'b10110, 5, "basic");
    checks++;
    if (pulses_ov != 1) begin
      errors++;
      $display("FAIL basic pulses actual=%0d required=1", pulses_ov);
    end
  endtask

  task automatic test_overlap();
    mid_cycle_reset("overlap_rst");
    pulses_ov = 0;
    pulses_no = 0;
    drive_seq(16'b1011011, 7, "overlap");
    checks++;
    if (pulses_ov != 2) begin
      errors++;
      $display("FAIL overlap ovl pulses actual=%0d required=2", pulses_ov);
    end
    checks++;
    if (pulses_no != 1) begin
      errors++;
      $display("FAIL overlap novl pulses actual=%0d required=1", pulses_no);
    end
  endtask

  task automatic test_near_miss();
    mid_cycle_reset("nm_rst_a");
    pulses_ov = 0;
    drive_seq(16'b11011, 5, "near_11011");
    checks++;
    if (pulses_ov != 1) begin
      errors++;
      $display("FAIL near_11011 pulses actual=%0d required=1", pulses_ov);
    end
    mid_cycle_reset("nm_rst_b");
    pulses_ov = 0;
    drive_seq(16'b10011, 5, "near_10011");
    checks++;
    if (pulses_ov != 0) begin
      errors++;
      $display("FAIL near_10011 pulses actual=%0d required=0", pulses_ov);
    end
    mid_cycle_reset("nm_rst_c");
    pulses_ov = 0;
    drive_seq(16'b101011, 6, "near_101011");
    checks++;
    if (pulses_ov != 1) begin
      errors++;
      $display("FAIL near_101011 pulses actual=%0d required=1", pulses_ov);
    end
  endtask

  task automatic test_mid_reset();
    mid_cycle_reset("mid_rst_a");
    pulses_ov = 0;
    drive_seq(16'b101, 3, "mid_prefix");
    mid_cycle_reset("mid_rst_b");
    drive_bit(1'b1, "mid_after");
    checks++;
    if (pulses_ov != 0) begin
      errors++;
      $display("FAIL mid_after pulses actual=%0d required=0", pulses_ov);
    end
    drive_seq(16'b011, 3, "mid_tail");
    checks++;
    if (pulses_ov != 1) begin
      errors++;
      $display("FAIL mid_tail pulses actual=%0d required=1", pulses_ov);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      drive_bit(1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    dut_if.rst_n = 1'b1;
    dut_if.s_in = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_if.valid !== 1'b0 || valid_no !== 1'b0) begin
      errors++;
      $display("FAIL power_on_reset actual=%b%b required=00", dut_if.valid, valid_no);
    end
    test_reset();
    test_basic();
    test_overlap();
    test_near_miss();
    test_mid_reset();
    mid_cycle_reset("random_rst");
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/moore_fsm.md
Name: moore_fsm

Overview:
- Single-clock Moore-type serial sequence detector.
- Samples one bit per clock on s_in and asserts valid while the FSM sits in the state reached after the bit pattern 1011 (first-received bit first).
- Output depends only on the registered state.
- Sits behind a serial bit source; the bench drives and monitors it through the ifDut interface bundle (clk, rst_n, s_in, valid).

Parameters:
- OVERLAP, 1, 1 = detections may overlap (final "1" of 1011 starts the next match); 0 = no overlap, matching restarts from scratch after each detection.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active-high. Port name kept as rst_n per codebase; assertion level is 1 despite the suffix.
- s_in  input  1  serial data bit, sampled on every rising clk edge.
- valid  output  1  high for exactly one state (clock cycle) after a complete 1011 match.

Behaviour:
- Reset: rst_n=1 forces state=IDLE immediately, without waiting for a clock edge; valid=0 while reset is held. Release is synchronous to the next clk edge (first sample on the first rising edge with rst_n=0).
- States (typedef enum, 3-bit binary):
  - IDLE: nothing matched.
  - S1: "1" matched.
  - S10: "10" matched.
  - S101: "101" matched.
  - DET: "1011" matched.
- Transitions on posedge clk, next state for s_in=0 / s_in=1:
  - IDLE: 0 -> IDLE; 1 -> S1.
  - S1: 0 -> S10; 1 -> S1.
  - S10: 0 -> IDLE; 1 -> S101.
  - S101: 0 -> S10; 1 -> DET.
  - DET, OVERLAP=1: 0 -> S10; 1 -> S1.
  - DET, OVERLAP=0: 0 -> IDLE; 1 -> S1.
- Output:
  - valid = (state==DET), decoded from the state register only; never a combinational path from s_in.
  - Latency: if the final "1" is sampled at edge k, valid is high from edge k until edge k+1.
- Consecutive matches (OVERLAP=1): stream 1011011 gives two one-cycle valid pulses, separated by 2 low cycles.
- Mid-sequence reset: partial match is discarded and valid drops asynchronously. After release, matching restarts from IDLE.
- Illegal state encodings (5..7): next state = IDLE, valid=0.
- X on s_in: no requirement beyond not corrupting state after a clean reset.

Decomposition:
- moore_fsm_pkg holds:
  - the state enum typedef (IDLE, S1, S10, S101, DET);
  - the localparam pattern constant 4'b1011 for documentation and checks.
- Verification interface ifDut bundles clk, rst_n, s_in, valid.
- Single module: one always_ff for the state register (async reset), one always_comb for next state, one continuous assign for valid. No sub-module.

Test Plan:
- Reset: hold rst_n=1 for 8 cycles with random s_in -> valid=0 throughout. Assert rst_n mid-cycle -> state=IDLE with no clock edge needed.
- Basic detect: after reset, drive 1,0,1,1,0 -> valid=1 only in the cycle following the 4th bit, 0 otherwise.
- Overlap, OVERLAP=1: drive 1,0,1,1,0,1,1 -> valid pulses after bit 4 and after bit 7 (exactly 2 pulses).
- Same stream with OVERLAP=0 -> single pulse after bit 4.
- Near-misses:
  - 1,1,0,1,1 -> one pulse after bit 5 (S1 self-loop).
  - 1,0,0,1,1 -> no pulse (S10 --0--> IDLE).
  - 1,0,1,0,1,1 -> one pulse after bit 6 (S101 --0--> S10).
- Reset mid-sequence: drive 1,0,1, pulse rst_n, then 1 -> no pulse. Then 0,1,1 -> pulse after the last bit. Run 1000-cycle random stream against a reference shift-register model -> zero mismatches.
